pkt_fifo_ctrl: RTL and testbench

//  Single-clock store-and-forward packet FIFO for one switch port. Accepts frame words on a

---
 rtl/pkt_fifo_pkg.sv | 20 ++
 rtl/RAM_True_Dual_Port.sv | 38 +++
 rtl/pkt_fifo_out_buf.sv | 77 +++++++
 rtl/pkt_fifo_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pkt_fifo_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_fifo_pkg.sv
// Shared definitions for the store-and-forward packet FIFO: RAM word layout and
// the write-side state encoding.
package pkt_fifo_pkg;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_FILL,
    WR_DISCARD
  } wr_state_e;

  // A RAM word is {last, data}: the end-of-frame flag sits just above the payload.
  function automatic int last_bit(input int data_width);
    return data_width;
  endfunction

  function automatic int ram_word_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/RAM_True_Dual_Port.sv
// Two-port RAM with registered reads; both ports are assumed to share one clock.
// READ_NEW_DATA selects write-through (1) or old-data (0) behaviour on a same-port write.
module RAM_True_Dual_Port #(
  parameter int WORD_WIDTH    = 9,
  parameter int ADDR_WIDTH    = 10,
  parameter bit READ_NEW_DATA = 1'b0
) (
  input  logic                  clock_A,
  input  logic                  wren_A,
  input  logic [ADDR_WIDTH-1:0] addr_A,
  input  logic [WORD_WIDTH-1:0] write_data_A,
  output logic [WORD_WIDTH-1:0] read_data_A,
  input  logic                  clock_B,
  input  logic                  wren_B,
  input  logic [ADDR_WIDTH-1:0] addr_B,
  input  logic [WORD_WIDTH-1:0] write_data_B,
  output logic [WORD_WIDTH-1:0] read_data_B
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  // Writes from both ports live in one process so the array has a single driver.
  always_ff @(posedge clock_A) begin
    if (wren_A) mem[addr_A] <= write_data_A;
    if (wren_B) mem[addr_B] <= write_data_B;
  end

  always_ff @(posedge clock_A) begin
    read_data_A <= (READ_NEW_DATA && wren_A) ? write_data_A : mem[addr_A];
  end

  always_ff @(posedge clock_B) begin
    read_data_B <= (READ_NEW_DATA && wren_B) ? write_data_B : mem[addr_B];
  end

endmodule

// File: rtl/pkt_fifo_out_buf.sv
// Two-entry output skid buffer fed by a 1-cycle-latency RAM read port; it requests
// a read only when the word is guaranteed a slot on arrival.
module pkt_fifo_out_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_avail,
  output logic                  rd_issue,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  logic [1:0]            count_reg;
  logic                  inflight_reg;
  logic                  wr_idx_reg;
  logic                  rd_idx_reg;
  logic                  push;
  logic                  pop;
  logic [2:0]            occupancy;
  logic [DATA_WIDTH-1:0] entry_data [2];
  logic                  entry_last [2];

  assign push      = inflight_reg;
  assign out_valid = (count_reg != 2'd0);
  assign pop       = out_valid & out_ready;

  // Counting this cycle's pop lets a read issue every cycle while draining.
  assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign rd_issue  = rd_avail && (occupancy < 3'd2);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] data_q;
      logic                  last_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          data_q <= '0;
          last_q <= 1'b0;
        end else if (push && (wr_idx_reg == 1'(gi))) begin
          data_q <= rd_data;
          last_q <= rd_last;
        end
      end

      assign entry_data[gi] = data_q;
      assign entry_last[gi] = last_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg    <= 2'd0;
      inflight_reg <= 1'b0;
      wr_idx_reg   <= 1'b0;
      rd_idx_reg   <= 1'b0;
    end else begin
      inflight_reg <= rd_issue;
      if (push) wr_idx_reg <= ~wr_idx_reg;
      if (pop)  rd_idx_reg <= ~rd_idx_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign out_data = entry_data[rd_idx_reg];
  assign out_last = entry_last[rd_idx_reg];

endmodule

// File: rtl/pkt_fifo_ctrl.sv
// Store-and-forward packet FIFO: frames are written speculatively and only become
// readable once their last word arrives clean; bad or overflowing frames are rewound.
module pkt_fifo_ctrl
  import pkt_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_FRAMES = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic                             in_last,
  input  logic                             in_err,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_last,
  output logic [$clog2(MAX_FRAMES+1)-1:0]  frame_cnt,
  output logic                             drop_pulse
);

  localparam int LAST_BIT   = last_bit(DATA_WIDTH);
  localparam int WORD_WIDTH = ram_word_width(DATA_WIDTH);
  localparam int CNT_WIDTH  = $clog2(MAX_FRAMES + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_PTR = {1'b1, {ADDR_WIDTH{1'b0}}};

  wr_state_e             state_reg, state_next;
  logic [ADDR_WIDTH:0]   wr_ptr_reg, wr_ptr_next;
  logic [ADDR_WIDTH:0]   wr_commit_reg, wr_commit_next;
  logic [ADDR_WIDTH:0]   rd_ptr_reg;
  logic [CNT_WIDTH-1:0]  frame_cnt_reg;
  logic                  ready_reg;
  logic                  drop_reg, drop_next;
  logic                  commit;
  logic                  ram_we;
  logic                  accept;
  logic                  full;
  logic                  frames_full;
  logic                  rd_avail;
  logic                  rd_issue;
  logic                  out_fire_last;
  logic [WORD_WIDTH-1:0] ram_q;
  logic [WORD_WIDTH-1:0] ram_unused_q;

  assign in_ready    = ready_reg;
  assign drop_pulse  = drop_reg;
  assign frame_cnt   = frame_cnt_reg;
  assign accept      = in_valid & ready_reg;
  // Uncommitted words count toward fullness because they occupy RAM too.
  assign full        = ((wr_ptr_reg - rd_ptr_reg) == DEPTH_PTR);
  assign frames_full = (frame_cnt_reg == CNT_WIDTH'(MAX_FRAMES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= WR_IDLE;
      wr_ptr_reg    <= '0;
      wr_commit_reg <= '0;
      drop_reg      <= 1'b0;
      ready_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      wr_commit_reg <= wr_commit_next;
      drop_reg      <= drop_next;
      ready_reg     <= 1'b1;
    end
  end

  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    wr_commit_next = wr_commit_reg;
    drop_next      = 1'b0;
    commit         = 1'b0;
    ram_we         = 1'b0;
    case (state_reg)
      WR_IDLE, WR_FILL: begin
        if (accept) begin
          if (full || ((state_reg == WR_IDLE) && frames_full)) begin
            wr_ptr_next = wr_commit_reg;
            drop_next   = 1'b1;
            state_next  = in_last ? WR_IDLE : WR_DISCARD;
          end else begin
            ram_we = 1'b1;
            if (!in_last) begin
              wr_ptr_next = wr_ptr_reg + 1'b1;
              state_next  = WR_FILL;
            end else if (in_err) begin
              wr_ptr_next = wr_commit_reg;
              drop_next   = 1'b1;
              state_next  = WR_IDLE;
            end else begin
              wr_ptr_next    = wr_ptr_reg + 1'b1;
              wr_commit_next = wr_ptr_reg + 1'b1;
              commit         = 1'b1;
              state_next     = WR_IDLE;
            end
          end
        end
      end
      WR_DISCARD: begin
        if (accept && in_last) state_next = WR_IDLE;
      end
      default: state_next = WR_IDLE;
    endcase
  end

  // Reads never pass wr_commit, so they cannot touch the word being written.
  assign rd_avail      = (rd_ptr_reg != wr_commit_reg);
  assign out_fire_last = out_valid & out_ready & out_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_reg    <= '0;
      frame_cnt_reg <= '0;
    end else begin
      if (rd_issue) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({commit, out_fire_last})
        2'b10:   frame_cnt_reg <= frame_cnt_reg + 1'b1;
        2'b01:   frame_cnt_reg <= frame_cnt_reg - 1'b1;
        default: frame_cnt_reg <= frame_cnt_reg;
      endcase
    end
  end

  RAM_True_Dual_Port #(
    .WORD_WIDTH    (WORD_WIDTH),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .READ_NEW_DATA (1'b0)
  ) u_ram (
    .clock_A      (clk),
    .wren_A       (ram_we),
    .addr_A       (wr_ptr_reg[ADDR_WIDTH-1:0]),
    .write_data_A ({in_last, in_data}),
    .read_data_A  (ram_unused_q),
    .clock_B      (clk),
    .wren_B       (1'b0),
    .addr_B       (rd_ptr_reg[ADDR_WIDTH-1:0]),
    .write_data_B ({WORD_WIDTH{1'b0}}),
    .read_data_B  (ram_q)
  );

  pkt_fifo_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_avail  (rd_avail),
    .rd_issue  (rd_issue),
    .rd_data   (ram_q[DATA_WIDTH-1:0]),
    .rd_last   (ram_q[LAST_BIT]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_pkt_fifo_ctrl.sv
// Directed bench for pkt_fifo_ctrl: a default-size instance and a small instance
// (16 words, 4 frames) for the overflow and frame-limit cases.
`timescale 1ns/1ps
module tb_pkt_fifo_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid, in_ready, in_last, in_err;
  logic       out_valid, out_ready, out_last, drop_pulse;
  logic [7:0] in_data, out_data;
  logic [6:0] frame_cnt;

  logic       s_in_valid, s_in_ready, s_in_last, s_in_err;
  logic       s_out_valid, s_out_ready, s_out_last, s_drop_pulse;
  logic [7:0] s_in_data, s_out_data;
  logic [2:0] s_frame_cnt;

  pkt_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .MAX_FRAMES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_err(in_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .frame_cnt(frame_cnt), .drop_pulse(drop_pulse)
  );

  pkt_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .MAX_FRAMES(4)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .in_last(s_in_last), .in_err(s_in_err),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_last(s_out_last), .frame_cnt(s_frame_cnt), .drop_pulse(s_drop_pulse)
  );

  int checks = 0;
  int fails  = 0;
  int drops  = 0;
  int s_drops = 0;
  logic [8:0] rxq[$];
  logic [8:0] s_rxq[$];

  // Output transfers and drop pulses are observed mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (drop_pulse === 1'b1) drops++;
    if (s_drop_pulse === 1'b1) s_drops++;
    if (out_valid === 1'b1 && out_ready === 1'b1) rxq.push_back({out_last, out_data});
    if (s_out_valid === 1'b1 && s_out_ready === 1'b1) s_rxq.push_back({s_out_last, s_out_data});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic e);
    in_valid = 1'b1; in_data = d; in_last = l; in_err = e;
    step();
    in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
  endtask

  task automatic s_send(input logic [7:0] d, input logic l, input logic e);
    s_in_valid = 1'b1; s_in_data = d; s_in_last = l; s_in_err = e;
    step();
    s_in_valid = 1'b0; s_in_last = 1'b0; s_in_err = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int limit, output bit ok);
    int c = 0;
    while (rxq.size() < n && c < limit) begin step(); c++; end
    ok = (rxq.size() >= n);
  endtask

  task automatic s_wait_rx(input int n, input int limit, output bit ok);
    int c = 0;
    while (s_rxq.size() < n && c < limit) begin step(); c++; end
    ok = (s_rxq.size() >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; in_data = 0; in_last = 0; in_err = 0; out_ready = 0;
    s_in_valid = 0; s_in_data = 0; s_in_last = 0; s_in_err = 0; s_out_ready = 0;
    repeat (3) step();
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (frame_cnt !== 7'd0) begin fails++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
    checks++; if (drop_pulse !== 1'b0) begin fails++; $display("FAIL rst_drop: got %b want 0", drop_pulse); end
    checks++; if ({out_last, out_data} !== 9'h000) begin fails++; $display("FAIL rst_out_word: got %h want 000", {out_last, out_data}); end
    checks++; if (s_frame_cnt !== 3'd0) begin fails++; $display("FAIL rst_s_frame_cnt: got %0d want 0", s_frame_cnt); end
    rst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_after: got %b want 1", in_ready); end
    checks++; if (s_in_ready !== 1'b1) begin fails++; $display("FAIL rst_s_ready_after: got %b want 1", s_in_ready); end
    $display("reset released");
  endtask

  task automatic test_single_frame();
    int lat = 0;
    rxq.delete();
    out_ready = 1'b1;
    send(8'h11, 0, 0); send(8'h12, 0, 0); send(8'h13, 0, 0); send(8'h14, 1, 0);
    $display("tx frame 11..14 len 4");
    checks++; if (frame_cnt !== 7'd1) begin fails++; $display("FAIL t1_cnt_commit: got %0d want 1", frame_cnt); end
    while (out_valid !== 1'b1 && lat < 10) begin step(); lat++; end
    checks++; if (lat != 2) begin fails++; $display("FAIL t1_latency: got %0d want 2", lat); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL t1_valid[%0d]: got %b want 1", k, out_valid); end
      checks++; if (out_data !== 8'(8'h11 + k)) begin fails++; $display("FAIL t1_data[%0d]: got %h want %h", k, out_data, 8'(8'h11 + k)); end
      checks++; if (out_last !== (k == 3)) begin fails++; $display("FAIL t1_last[%0d]: got %b want %b", k, out_last, (k == 3)); end
      step();
    end
    checks++; if (frame_cnt !== 7'd0) begin fails++; $display("FAIL t1_cnt_end: got %0d want 0", frame_cnt); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t1_valid_end: got %b want 0", out_valid); end
  endtask

  task automatic test_err_drop();
    logic [8:0] exp_w [5] = '{9'h021, 9'h022, 9'h123, 9'h041, 9'h142};
    int d0;
    bit ok;
    rxq.delete();
    out_ready = 1'b0;
    d0 = drops;
    send(8'h21, 0, 0); send(8'h22, 0, 0); send(8'h23, 1, 0);
    $display("tx frame A len 3");
    checks++; if (frame_cnt !== 7'd1) begin fails++; $display("FAIL t2_cnt_a: got %0d want 1", frame_cnt); end
    for (int i = 0; i < 5; i++) send(8'(8'h31 + i), (i == 4), (i == 4));
    $display("tx frame B len 5 errored");
    checks++; if (frame_cnt !== 7'd1) begin fails++; $display("FAIL t2_cnt_b: got %0d want 1", frame_cnt); end
    send(8'h41, 0, 0); send(8'h42, 1, 0);
    $display("tx frame C len 2");
    checks++; if (frame_cnt !== 7'd2) begin fails++; $display("FAIL t2_cnt_peak: got %0d want 2", frame_cnt); end
    repeat (4) step();
    checks++; if (drops - d0 != 1) begin fails++; $display("FAIL t2_drops: got %0d want 1", drops - d0); end
    checks++; if ({out_valid, out_data} !== 9'h121) begin fails++; $display("FAIL t2_stall_hold: got %h want 121", {out_valid, out_data}); end
    out_ready = 1'b1;
    wait_rx(5, 40, ok);
    checks++; if (!ok) begin fails++; $display("FAIL t2_rx_timeout: got %0d words want 5", rxq.size()); end
    for (int i = 0; i < 5 && i < rxq.size(); i++) begin
      checks++; if (rxq[i] !== exp_w[i]) begin fails++; $display("FAIL t2_word[%0d]: got %h want %h", i, rxq[i], exp_w[i]); end
    end
    repeat (4) step();
    checks++; if (rxq.size() != 5) begin fails++; $display("FAIL t2_count: got %0d want 5", rxq.size()); end
    checks++; if (frame_cnt !== 7'd0) begin fails++; $display("FAIL t2_cnt_end: got %0d want 0", frame_cnt); end
  endtask

  task automatic test_overflow();
    int d0;
    bit ok;
    s_rxq.delete();
    s_out_ready = 1'b0;
    d0 = s_drops;
    for (int i = 0; i < 20; i++) begin
      s_send(8'(8'h50 + i), (i == 19), 1'b0);
      if (i == 16) begin
        checks++; if (s_drop_pulse !== 1'b1) begin fails++; $display("FAIL t3_drop_at17: got %b want 1", s_drop_pulse); end
      end
      if (i == 17) begin
        checks++; if (s_drop_pulse !== 1'b0) begin fails++; $display("FAIL t3_drop_once: got %b want 0", s_drop_pulse); end
      end
    end
    $display("tx frame len 20 into 16-word fifo");
    step();
    checks++; if (s_frame_cnt !== 3'd0) begin fails++; $display("FAIL t3_cnt_drop: got %0d want 0", s_frame_cnt); end
    checks++; if (s_drops - d0 != 1) begin fails++; $display("FAIL t3_drops: got %0d want 1", s_drops - d0); end
    s_send(8'h61, 0, 0); s_send(8'h62, 0, 0); s_send(8'h63, 1, 0);
    $display("tx frame 61..63 len 3");
    checks++; if (s_frame_cnt !== 3'd1) begin fails++; $display("FAIL t3_cnt_next: got %0d want 1", s_frame_cnt); end
    s_out_ready = 1'b1;
    s_wait_rx(3, 20, ok);
    checks++; if (!ok) begin fails++; $display("FAIL t3_rx_timeout: got %0d words want 3", s_rxq.size()); end
    for (int i = 0; i < 3 && i < s_rxq.size(); i++) begin
      checks++; if (s_rxq[i] !== {(i == 2), 8'(8'h61 + i)}) begin fails++; $display("FAIL t3_word[%0d]: got %h want %h", i, s_rxq[i], {(i == 2), 8'(8'h61 + i)}); end
    end
    repeat (3) step();
    checks++; if (s_drops - d0 != 1) begin fails++; $display("FAIL t3_drops_end: got %0d want 1", s_drops - d0); end
    checks++; if (s_frame_cnt !== 3'd0) begin fails++; $display("FAIL t3_cnt_end: got %0d want 0", s_frame_cnt); end
    s_out_ready = 1'b0;
  endtask

  task automatic test_max_frames();
    logic [7:0] exp_d [5] = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h76};
    int d0;
    bit ok;
    s_rxq.delete();
    s_out_ready = 1'b0;
    d0 = s_drops;
    for (int i = 0; i < 4; i++) s_send(8'(8'h71 + i), 1'b1, 1'b0);
    $display("tx 4 one-word frames 71..74");
    checks++; if (s_frame_cnt !== 3'd4) begin fails++; $display("FAIL t6_cnt_full: got %0d want 4", s_frame_cnt); end
    s_send(8'h75, 1, 0);
    $display("tx frame 75 at frame limit");
    step();
    checks++; if (s_frame_cnt !== 3'd4) begin fails++; $display("FAIL t6_cnt_drop: got %0d want 4", s_frame_cnt); end
    checks++; if (s_drops - d0 != 1) begin fails++; $display("FAIL t6_drops: got %0d want 1", s_drops - d0); end
    s_out_ready = 1'b1;
    step();
    s_out_ready = 1'b0;
    checks++; if (s_frame_cnt !== 3'd3) begin fails++; $display("FAIL t6_cnt_read: got %0d want 3", s_frame_cnt); end
    s_send(8'h76, 1, 0);
    $display("tx frame 76 after one read");
    step();
    checks++; if (s_frame_cnt !== 3'd4) begin fails++; $display("FAIL t6_cnt_accept: got %0d want 4", s_frame_cnt); end
    checks++; if (s_drops - d0 != 1) begin fails++; $display("FAIL t6_drops_end: got %0d want 1", s_drops - d0); end
    s_out_ready = 1'b1;
    s_wait_rx(5, 30, ok);
    checks++; if (!ok) begin fails++; $display("FAIL t6_rx_timeout: got %0d words want 5", s_rxq.size()); end
    for (int i = 0; i < 5 && i < s_rxq.size(); i++) begin
      checks++; if (s_rxq[i] !== {1'b1, exp_d[i]}) begin fails++; $display("FAIL t6_word[%0d]: got %h want %h", i, s_rxq[i], {1'b1, exp_d[i]}); end
    end
    repeat (3) step();
    checks++; if (s_frame_cnt !== 3'd0) begin fails++; $display("FAIL t6_cnt_end: got %0d want 0", s_frame_cnt); end
    s_out_ready = 1'b0;
  endtask

  task automatic test_random_stream();
    logic [8:0] expq[$];
    int lens [100];
    int total;
    int d0;
    rxq.delete();
    d0 = drops;
    for (int f = 0; f < 100; f++) begin
      lens[f] = $urandom_range(1, 12);
      for (int w = 0; w < lens[f]; w++) expq.push_back({(w == lens[f] - 1), 8'($urandom)});
    end
    total = expq.size();
    fork
      begin
        int idx = 0;
        for (int f = 0; f < 100; f++) begin
          int guard = 0;
          while (frame_cnt >= 7'd60 && guard < 2000) begin step(); guard++; end
          for (int w = 0; w < lens[f]; w++) begin
            in_valid = 1'b1; in_data = expq[idx][7:0]; in_last = expq[idx][8]; in_err = 1'b0;
            step();
            idx++;
          end
          in_valid = 1'b0; in_last = 1'b0;
          $display("tx random frame %0d len %0d", f, lens[f]);
          if ($urandom_range(0, 3) == 0) step();
        end
      end
      begin
        int cyc = 0;
        while (rxq.size() < total && cyc < 20000) begin
          out_ready = 1'($urandom_range(0, 1));
          step();
          cyc++;
        end
      end
    join
    out_ready = 1'b0;
    checks++; if (rxq.size() != total) begin fails++; $display("FAIL t4_count: got %0d want %0d", rxq.size(), total); end
    for (int i = 0; i < total && i < rxq.size(); i++) begin
      checks++; if (rxq[i] !== expq[i]) begin fails++; $display("FAIL t4_word[%0d]: got %h want %h", i, rxq[i], expq[i]); end
    end
    repeat (3) step();
    checks++; if (frame_cnt !== 7'd0) begin fails++; $display("FAIL t4_cnt_end: got %0d want 0", frame_cnt); end
    checks++; if (drops != d0) begin fails++; $display("FAIL t4_drops: got %0d want 0", drops - d0); end
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    rxq.delete();
    out_ready = 1'b0;
    for (int c = 0; c < 18; c++) send(8'(8'hA0 + c), (c == 4 || c == 10 || c == 17), 1'b0);
    $display("tx frames len 5,6,7 back to back");
    checks++; if (frame_cnt !== 7'd3) begin fails++; $display("FAIL b2b_cnt: got %0d want 3", frame_cnt); end
    repeat (3) step();
    out_ready = 1'b1;
    while (out_valid !== 1'b1 && lat < 10) begin step(); lat++; end
    checks++; if (lat != 0) begin fails++; $display("FAIL b2b_head_ready: got %0d cycles want 0", lat); end
    for (int c = 0; c < 18; c++) begin
      checks++; if ({out_valid, out_last, out_data} !== {1'b1, (c == 4 || c == 10 || c == 17), 8'(8'hA0 + c)}) begin
        fails++;
        $display("FAIL b2b_word[%0d]: got v=%b l=%b d=%h want v=1 l=%b d=%h", c, out_valid, out_last, out_data, (c == 4 || c == 10 || c == 17), 8'(8'hA0 + c));
      end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_valid_end: got %b want 0", out_valid); end
    checks++; if (frame_cnt !== 7'd0) begin fails++; $display("FAIL b2b_cnt_end: got %0d want 0", frame_cnt); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int d0;
    bit ok;
    rxq.delete();
    out_ready = 1'b0;
    d0 = drops;
    send(8'h81, 0, 0); send(8'h82, 1, 0); send(8'h83, 1, 0);
    send(8'h84, 0, 0); send(8'h85, 0, 0);
    $display("tx 2 frames plus partial, then reset");
    checks++; if (frame_cnt !== 7'd2) begin fails++; $display("FAIL t5_cnt_pre: got %0d want 2", frame_cnt); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t5_valid: got %b want 0", out_valid); end
    checks++; if (frame_cnt !== 7'd0) begin fails++; $display("FAIL t5_cnt: got %0d want 0", frame_cnt); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL t5_ready_low: got %b want 0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL t5_ready_high: got %b want 1", in_ready); end
    out_ready = 1'b1;
    send(8'h91, 0, 0); send(8'h92, 0, 0); send(8'h93, 1, 0);
    $display("tx frame 91..93 len 3");
    wait_rx(3, 20, ok);
    checks++; if (!ok) begin fails++; $display("FAIL t5_rx_timeout: got %0d words want 3", rxq.size()); end
    for (int i = 0; i < 3 && i < rxq.size(); i++) begin
      checks++; if (rxq[i] !== {(i == 2), 8'(8'h91 + i)}) begin fails++; $display("FAIL t5_word[%0d]: got %h want %h", i, rxq[i], {(i == 2), 8'(8'h91 + i)}); end
    end
    repeat (3) step();
    checks++; if (rxq.size() != 3) begin fails++; $display("FAIL t5_count: got %0d want 3", rxq.size()); end
    checks++; if (drops != d0) begin fails++; $display("FAIL t5_drops: got %0d want 0", drops - d0); end
    checks++; if (frame_cnt !== 7'd0) begin fails++; $display("FAIL t5_cnt_end: got %0d want 0", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_err_drop();
    test_overflow();
    test_max_frames();
    test_random_stream();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
